// File: rtl/regfile_sb.sv
// Parametrised register file: two registered read ports, writeback and link write ports,
// write-first bypass, optional hardwired zero register and a per-register pending-write scoreboard.
module regfile_sb #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned LINK_REG    = 31,
   parameter bit          ZERO_REG_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      ra1,
   input  logic [ADDR_W-1:0]      ra2,
   output logic [DATA_W-1:0]      rd1,
   output logic [DATA_W-1:0]      rd2,
   output logic                   rd_valid,
   output logic [1:0]             rd_hazard,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      wa,
   input  logic [DATA_W-1:0]      wd,
   input  logic                   link_en,
   input  logic [DATA_W-1:0]      link_pc,
   input  logic                   iss_en,
   input  logic [ADDR_W-1:0]      iss_addr,
   output logic [(2**ADDR_W)-1:0] busy
);

   localparam int unsigned       DEPTH  = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d, busy_clr;
   logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
   logic              rd_valid_q, rd_valid_d;
   logic [1:0]        rd_hazard_q, rd_hazard_d;
   logic [DATA_W-1:0] link_data;

   assign link_data = DATA_W'(link_pc + DATA_W'(1));

   // Write-first read value: link beats writeback, zero register beats both.
   function automatic logic [DATA_W-1:0] bypass_val(
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] stored,
      input logic              lnk,
      input logic [DATA_W-1:0] ldata,
      input logic              wen,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      logic [DATA_W-1:0] v;
      v = stored;
      if (wen && (a == waddr)) v = wdata;
      if (lnk && (a == LINK_A)) v = ldata;
      if (ZERO_REG_EN && (a == '0)) v = '0;
      return v;
   endfunction

   // Register array update; link is applied last so it wins on LINK_REG.
   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[wa] = wd;
      if (link_en) regs_d[LINK_A] = link_data;
      if (ZERO_REG_EN) regs_d[0] = '0;
   end

   // Scoreboard: clears first, then issue sets so a new producer wins.
   always_comb begin
      busy_clr = busy_q;
      if (we) busy_clr[wa] = 1'b0;
      if (link_en) busy_clr[LINK_A] = 1'b0;
      busy_d = busy_clr;
      if (iss_en) busy_d[iss_addr] = 1'b1;
      if (ZERO_REG_EN) busy_d[0] = 1'b0;
   end

   // Read ports; hazard sees same-cycle clears but not same-cycle issues.
   always_comb begin
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      rd_valid_d  = rd_en;
      rd_hazard_d = '0;
      if (rd_en) begin
         rd1_d       = bypass_val(ra1, regs_q[ra1], link_en, link_data, we, wa, wd);
         rd2_d       = bypass_val(ra2, regs_q[ra2], link_en, link_data, we, wa, wd);
         rd_hazard_d = {busy_clr[ra2], busy_clr[ra1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         regs_q      <= '{default: '0};
         busy_q      <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_hazard_q <= '0;
      end else begin
         regs_q      <= regs_d;
         busy_q      <= busy_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         rd_valid_q  <= rd_valid_d;
         rd_hazard_q <= rd_hazard_d;
      end
   end

   assign rd1       = rd1_q;
   assign rd2       = rd2_q;
   assign rd_valid  = rd_valid_q;
   assign rd_hazard = rd_hazard_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table for the corner cases, then random traffic
// checked against an array/bitmask model of the register file and scoreboard.
module tb_regfile_sb;

   typedef struct {
      bit          reset;
      bit          rd_en;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      bit          we;
      logic [4:0]  wa;
      logic [31:0] wd;
      bit          link_en;
      logic [31:0] link_pc;
      bit          iss_en;
      logic [4:0]  iss_addr;
   } in_t;

   typedef struct {
      in_t         in;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic        e_v;
      logic [1:0]  e_haz;
      logic [31:0] e_busy;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        rd_en;
   logic [4:0]  ra1, ra2;
   logic [31:0] rd1, rd2;
   logic        rd_valid;
   logic [1:0]  rd_hazard;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        link_en;
   logic [31:0] link_pc;
   logic        iss_en;
   logic [4:0]  iss_addr;
   logic [31:0] busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_busy;
   logic [31:0] m_rd1, m_rd2;
   logic        m_v;
   logic [1:0]  m_haz;

   vec_t tbl[$];

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .LINK_REG(31), .ZERO_REG_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
      .rd1(rd1), .rd2(rd2), .rd_valid(rd_valid), .rd_hazard(rd_hazard),
      .we(we), .wa(wa), .wd(wd), .link_en(link_en), .link_pc(link_pc),
      .iss_en(iss_en), .iss_addr(iss_addr), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic in_t mk(bit r, bit re, logic [4:0] a1, logic [4:0] a2,
                              bit w, logic [4:0] wad, logic [31:0] wdat,
                              bit l, logic [31:0] pc, bit i, logic [4:0] ia);
      in_t v;
      v.reset = r;  v.rd_en = re;  v.ra1 = a1;  v.ra2 = a2;
      v.we = w;  v.wa = wad;  v.wd = wdat;
      v.link_en = l;  v.link_pc = pc;  v.iss_en = i;  v.iss_addr = ia;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Register value as seen by a reader in the writing cycle.
   function automatic logic [31:0] mval(input in_t v, input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (v.link_en && a == 5'd31) return v.link_pc + 32'd1;
      if (v.we && v.wa == a) return v.wd;
      return m_regs[a];
   endfunction

   function automatic logic mhaz(input in_t v, input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (v.we && v.wa == a) return 1'b0;
      if (v.link_en && a == 5'd31) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_step(input in_t v);
      if (!v.reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_busy = 32'd0;  m_rd1 = 32'd0;  m_rd2 = 32'd0;  m_v = 1'b0;  m_haz = 2'b00;
      end else begin
         if (v.rd_en) begin
            m_rd1 = mval(v, v.ra1);
            m_rd2 = mval(v, v.ra2);
            m_haz = {mhaz(v, v.ra2), mhaz(v, v.ra1)};
            m_v   = 1'b1;
         end else begin
            m_v   = 1'b0;
            m_haz = 2'b00;
         end
         if (v.we && v.wa != 5'd0) m_regs[v.wa] = v.wd;
         if (v.link_en) m_regs[31] = v.link_pc + 32'd1;
         if (v.we) m_busy[v.wa] = 1'b0;
         if (v.link_en) m_busy[31] = 1'b0;
         if (v.iss_en && v.iss_addr != 5'd0) m_busy[v.iss_addr] = 1'b1;
      end
   endtask

   // Drive one cycle, advance the model, and sample just after the edge.
   task automatic apply(input in_t v);
      reset = v.reset;  rd_en = v.rd_en;  ra1 = v.ra1;  ra2 = v.ra2;
      we = v.we;  wa = v.wa;  wd = v.wd;
      link_en = v.link_en;  link_pc = v.link_pc;
      iss_en = v.iss_en;  iss_addr = v.iss_addr;
      model_step(v);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] raddr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) return 5'd31;
      return 5'($urandom_range(0, 5));
   endfunction

   initial begin
      in_t v;
      // reset, rd_en, ra1, ra2, we, wa, wd, link_en, link_pc, iss_en, iss_addr | rd1, rd2, v, haz, busy
      tbl.push_back('{mk(0,0,5'd0,5'd0,1,5'd5,32'hAAAA_AAAA,0,32'd0,0,5'd0), 32'h0, 32'h0, 1'b0, 2'b00, 32'h0});
      tbl.push_back('{mk(0,0,5'd0,5'd0,1,5'd5,32'hAAAA_AAAA,0,32'd0,0,5'd0), 32'h0, 32'h0, 1'b0, 2'b00, 32'h0});
      tbl.push_back('{mk(1,1,5'd5,5'd0,0,5'd0,32'h0,0,32'd0,0,5'd0), 32'h0, 32'h0, 1'b1, 2'b00, 32'h0});
      tbl.push_back('{mk(1,1,5'd7,5'd0,1,5'd7,32'h1234,0,32'd0,0,5'd0), 32'h1234, 32'h0, 1'b1, 2'b00, 32'h0});
      tbl.push_back('{mk(1,0,5'd0,5'd0,1,5'd0,32'h5,0,32'd0,0,5'd0), 32'h1234, 32'h0, 1'b0, 2'b00, 32'h0});
      tbl.push_back('{mk(1,1,5'd0,5'd7,0,5'd0,32'h0,0,32'd0,0,5'd0), 32'h0, 32'h1234, 1'b1, 2'b00, 32'h0});
      tbl.push_back('{mk(1,0,5'd0,5'd0,1,5'd31,32'h55,0,32'd0,0,5'd0), 32'h0, 32'h1234, 1'b0, 2'b00, 32'h0});
      tbl.push_back('{mk(1,0,5'd0,5'd0,1,5'd31,32'h9,1,32'hFFFF_FFFF,0,5'd0), 32'h0, 32'h1234, 1'b0, 2'b00, 32'h0});
      tbl.push_back('{mk(1,1,5'd31,5'd31,0,5'd0,32'h0,0,32'd0,0,5'd0), 32'h0, 32'h0, 1'b1, 2'b00, 32'h0});
      tbl.push_back('{mk(1,0,5'd0,5'd0,0,5'd0,32'h0,0,32'd0,1,5'd3), 32'h0, 32'h0, 1'b0, 2'b00, 32'h8});
      tbl.push_back('{mk(1,1,5'd3,5'd7,0,5'd0,32'h0,0,32'd0,0,5'd0), 32'h0, 32'h1234, 1'b1, 2'b01, 32'h8});
      tbl.push_back('{mk(1,1,5'd3,5'd3,1,5'd3,32'hCAFE,0,32'd0,0,5'd0), 32'hCAFE, 32'hCAFE, 1'b1, 2'b00, 32'h0});
      tbl.push_back('{mk(1,0,5'd0,5'd0,1,5'd4,32'h44,0,32'd0,1,5'd4), 32'hCAFE, 32'hCAFE, 1'b0, 2'b00, 32'h10});
      tbl.push_back('{mk(1,0,5'd0,5'd0,0,5'd0,32'h0,0,32'd0,1,5'd0), 32'hCAFE, 32'hCAFE, 1'b0, 2'b00, 32'h10});
      tbl.push_back('{mk(1,1,5'd6,5'd4,0,5'd0,32'h0,0,32'd0,1,5'd6), 32'h0, 32'h44, 1'b1, 2'b10, 32'h50});
      tbl.push_back('{mk(1,0,5'd0,5'd0,0,5'd0,32'h0,0,32'd0,1,5'd2), 32'h0, 32'h44, 1'b0, 2'b00, 32'h54});
      tbl.push_back('{mk(1,0,5'd0,5'd0,0,5'd0,32'h0,0,32'd0,1,5'd9), 32'h0, 32'h44, 1'b0, 2'b00, 32'h254});
      tbl.push_back('{mk(1,1,5'd2,5'd9,0,5'd0,32'h0,0,32'd0,0,5'd0), 32'h0, 32'h0, 1'b1, 2'b11, 32'h254});
      tbl.push_back('{mk(1,0,5'd0,5'd0,0,5'd0,32'h0,0,32'd0,1,5'd31), 32'h0, 32'h0, 1'b0, 2'b00, 32'h8000_0254});
      tbl.push_back('{mk(1,1,5'd31,5'd2,0,5'd0,32'h0,1,32'h100,0,5'd0), 32'h101, 32'h0, 1'b1, 2'b10, 32'h254});
      tbl.push_back('{mk(0,1,5'd31,5'd2,1,5'd6,32'h77,1,32'h200,1,5'd5), 32'h0, 32'h0, 1'b0, 2'b00, 32'h0});
      tbl.push_back('{mk(1,1,5'd31,5'd7,0,5'd0,32'h0,0,32'd0,0,5'd0), 32'h0, 32'h0, 1'b1, 2'b00, 32'h0});

      foreach (tbl[i]) begin
         apply(tbl[i].in);
         check($sformatf("row%0d rd1", i), rd1, tbl[i].e_rd1);
         check($sformatf("row%0d rd2", i), rd2, tbl[i].e_rd2);
         check($sformatf("row%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_v));
         check($sformatf("row%0d rd_hazard", i), 32'(rd_hazard), 32'(tbl[i].e_haz));
         check($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
      end

      for (int c = 0; c < 3000; c++) begin
         v.reset    = ($urandom_range(0, 149) != 0);
         v.rd_en    = ($urandom_range(0, 2) != 0);
         v.ra1      = raddr();
         v.ra2      = raddr();
         v.we       = ($urandom_range(0, 1) != 0);
         v.wa       = raddr();
         v.wd       = $urandom;
         v.link_en  = ($urandom_range(0, 7) == 0);
         v.link_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         v.iss_en   = ($urandom_range(0, 2) == 0);
         v.iss_addr = raddr();
         apply(v);
         check($sformatf("rnd%0d rd1", c), rd1, m_rd1);
         check($sformatf("rnd%0d rd2", c), rd2, m_rd2);
         check($sformatf("rnd%0d rd_valid", c), 32'(rd_valid), 32'(m_v));
         check($sformatf("rnd%0d rd_hazard", c), 32'(rd_hazard), 32'(m_haz));
         check($sformatf("rnd%0d busy", c), busy, m_busy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the processor's 32x32 register file.
- Two registered read ports, one write port and a dedicated link-write port for branch-and-link.
- Optional hardwired zero register and write-first bypass.
- Per-register pending-write scoreboard so decode can detect read-after-write hazards without external tracking.
- Sits between decode (read/issue side) and writeback (write side) of the pipeline.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- LINK_REG, 31, index written by the link port.
- ZERO_REG_EN, 1, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- rd_en  in  1  capture read addresses this cycle.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  registered read data, port 1.
- rd2  out  DATA_W  registered read data, port 2.
- rd_valid  out  1  rd1/rd2 updated by the previous cycle's rd_en.
- rd_hazard  out  2  bit k set if the port k+1 address was busy when sampled; registered alongside rdN.
- we  in  1  writeback write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- link_en  in  1  branch-and-link: write link_pc+1 to LINK_REG.
- link_pc  in  DATA_W  PC of the linking instruction.
- iss_en  in  1  mark a destination as pending.
- iss_addr  in  ADDR_W  destination being issued.
- busy  out  2**ADDR_W  scoreboard vector, bit i = register i pending.

Behaviour:
- Reset (reset==0 at posedge):
  - All registers, busy, rd1, rd2, rd_valid and rd_hazard go to 0.
  - Reset overrides every same-cycle write, link, issue or read.
  - Asserted mid-operation, it discards pending state; first read after reset deasserts returns 0.
- Read:
  - On posedge with rd_en=1, rd1<=value(ra1) and rd2<=value(ra2); rd_valid<=1 the next cycle. Latency is 1 cycle.
  - With rd_en=0: rd1/rd2 hold, rd_valid<=0, rd_hazard<=0.
- Bypass (write-first):
  - Computed per port, where value(a) is:
    - link data if link_en and a==LINK_REG;
    - else wd if we and a==wa;
    - else the array contents.
  - ZERO_REG_EN=1 and a==0 always gives 0.
- Write:
  - On posedge with we=1, regs[wa]<=wd.
  - With link_en=1, regs[LINK_REG]<=link_pc+1, modulo 2**DATA_W (wrap, no carry out).
  - If both target LINK_REG in the same cycle, link wins.
  - Writes to reg 0 are dropped when ZERO_REG_EN=1.
- Scoreboard:
  - iss_en sets busy[iss_addr].
  - we clears busy[wa]; link_en clears busy[LINK_REG].
  - Set and clear on the same index in one cycle: set wins (new producer issued).
  - busy[0] is forced 0 when ZERO_REG_EN=1.
  - rd_hazard[k] <= busy[addr_k] after applying same-cycle clears, i.e. a read bypassed from the writing cycle is not hazarded.
  - A same-cycle iss_en to a read address does not raise rd_hazard (the issuing instruction reads older operands).
- Boundaries:
  - Address 2**ADDR_W-1 and LINK_REG are valid ordinary targets.
  - Multiple busy bits may be set at once; no overflow state exists (one bit per register).

Test Plan:
- Reset: hold reset=0 two cycles with we=1, wa=5, wd=0xAAAA_AAAA; release, read ra1=5 -> rd1=0, rd_valid=1 next cycle, busy=0.
- Bypass: cycle N we=1, wa=7, wd=0x1234, rd_en=1, ra1=7, ra2=0 -> cycle N+1 rd1=0x1234, rd2=0. Write wa=0, wd=5, then read 0 -> 0.
- Link priority: link_en=1, link_pc=0xFFFF_FFFF, we=1, wa=31, wd=9 same cycle -> later read of reg 31 returns 0x0000_0000 (wrap; link wins).
- Scoreboard hazard: iss_en addr 3; next cycle rd_en, ra1=3 -> rd_hazard=2'b01. Then we wa=3 with rd_en ra1=3 same cycle -> rd_hazard=0, rd1=new data, busy[3]=0.
- Set-wins: iss_en addr 4 and we wa=4 same cycle -> busy[4]=1 afterwards. iss_en addr 0 -> busy[0] stays 0.
- Reset mid-operation: busy[2], busy[9] set, rd_valid=1; assert reset one cycle -> busy=0, rd1=rd2=0, rd_valid=0, rd_hazard=0.
